// File: rtl/lnext_responder_pkg.sv
// Shared types for the L_NEXT responder: command encoding, FSM states and
// line geometry constants used by the responder and its backing store.
package lnext_responder_pkg;

  localparam int LINEADDRBITS = 26;
  localparam int LINEWORDS    = 16;

  typedef enum logic [1:0] {
    NOP       = 2'b00,
    READ_OUT  = 2'b01,
    WRITE_OUT = 2'b10
  } l_next_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_DATA,
    WR_COMMIT
  } lnext_state_t;

endpackage

// File: rtl/lnext_store.sv
// Backing store: MEMLINES lines of LINEWORDS words, one whole-line write port,
// a combinational word read port and a per-line written bit cleared on reset.
module lnext_store
  import lnext_responder_pkg::*;
#(
  parameter int WORDBITS = 32,
  parameter int MEMLINES = 256,
  parameter int IDXBITS  = $clog2(MEMLINES),
  parameter int WCBITS   = $clog2(LINEWORDS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [IDXBITS-1:0]                 wr_index,
  input  logic [LINEWORDS-1:0][WORDBITS-1:0] wr_line,
  input  logic [IDXBITS-1:0]                 rd_index,
  input  logic [WCBITS-1:0]                  rd_word,
  output logic [WORDBITS-1:0]                rd_data,
  output logic                               rd_written
);

  // Line data is deliberately not reset; only the written bits are.
  logic [LINEWORDS-1:0][WORDBITS-1:0] mem_q [MEMLINES];
  logic [MEMLINES-1:0]                written_q, written_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_index] <= wr_line;
    end
  end

  always_comb begin
    written_d = written_q;
    if (wr_en) begin
      written_d[wr_index] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      written_q <= '0;
    end else begin
      written_q <= written_d;
    end
  end

  assign rd_data    = mem_q[rd_index][rd_word];
  assign rd_written = written_q[rd_index];

endmodule

// File: rtl/lnext_responder.sv
// Next-level memory model answering the cache's L_NEXT interface: line reads
// after a fixed latency, buffered line writes, and per-command counters.
module lnext_responder
  import lnext_responder_pkg::*;
#(
  parameter int WORDBITS = 32,
  parameter int LATENCY  = 4,
  parameter int MEMLINES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              cmd_in,
  input  logic [LINEADDRBITS-1:0] add_in,
  input  logic                    wr_valid,
  input  logic [WORDBITS-1:0]     wr_data,
  output logic                    rd_valid,
  output logic [WORDBITS-1:0]     rd_data,
  output logic                    rd_last,
  output logic                    wr_done,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
);

  localparam int IDXBITS = $clog2(MEMLINES);
  localparam int WCBITS  = $clog2(LINEWORDS);
  localparam logic [WCBITS-1:0] LAST_WORD = WCBITS'(LINEWORDS - 1);

  lnext_state_t                       state_q, state_d;
  logic [3:0]                         wait_q, wait_d;
  logic [WCBITS-1:0]                  word_q, word_d;
  logic [IDXBITS-1:0]                 idx_q, idx_d;
  logic [15:0]                        tag_q, tag_d;
  logic [LINEWORDS-1:0][WORDBITS-1:0] buf_q, buf_d;
  logic [31:0]                        rd_cnt_q, rd_cnt_d;
  logic [31:0]                        wr_cnt_q, wr_cnt_d;

  logic                               store_we;
  logic [WORDBITS-1:0]                store_word;
  logic                               store_written;
  logic [WORDBITS-1:0]                pattern;
  logic                               unused_add_hi;

  assign unused_add_hi = ^add_in[LINEADDRBITS-1:16];

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    word_d   = word_q;
    idx_d    = idx_q;
    tag_d    = tag_q;
    buf_d    = buf_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    store_we = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          // NOP and the unused 2'b11 encoding fall through untouched.
          case (cmd_in)
            READ_OUT: begin
              idx_d    = add_in[IDXBITS-1:0];
              tag_d    = add_in[15:0];
              rd_cnt_d = rd_cnt_q + 32'd1;
              wait_d   = 4'(LATENCY - 1);
              state_d  = RD_WAIT;
            end
            WRITE_OUT: begin
              idx_d   = add_in[IDXBITS-1:0];
              tag_d   = add_in[15:0];
              word_d  = '0;
              state_d = WR_DATA;
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        if (wait_q == 4'd0) begin
          word_d  = '0;
          state_d = RD_BURST;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RD_BURST: begin
        word_d = word_q + 1'b1;
        if (word_q == LAST_WORD) begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (wr_valid) begin
          buf_d[word_q] = wr_data;
          word_d        = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            state_d = WR_COMMIT;
          end
        end
      end
      WR_COMMIT: begin
        store_we = 1'b1;
        wr_cnt_d = wr_cnt_q + 32'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      tag_q    <= '0;
      buf_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      buf_q    <= buf_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  lnext_store #(
    .WORDBITS (WORDBITS),
    .MEMLINES (MEMLINES)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (store_we),
    .wr_index   (idx_q),
    .wr_line    (buf_q),
    .rd_index   (idx_q),
    .rd_word    (word_q),
    .rd_data    (store_word),
    .rd_written (store_written)
  );

  // Never-written lines read back as {line address low half, word number}.
  assign pattern = WORDBITS'({tag_q, 16'(word_q)});

  assign req_ready   = (state_q == IDLE) && !reset;
  assign rd_valid    = (state_q == RD_BURST);
  assign rd_data     = rd_valid ? (store_written ? store_word : pattern) : '0;
  assign rd_last     = rd_valid && (word_q == LAST_WORD);
  assign wr_done     = (state_q == WR_COMMIT);
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_lnext_responder.sv
// Directed self-checking bench for lnext_responder (LATENCY=4, MEMLINES=256).
module tb_lnext_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  cmd_in;
  logic [25:0] add_in;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wr_done;
  logic [31:0] read_count;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_fails  = 0;

  lnext_responder #(
    .WORDBITS (32),
    .LATENCY  (4),
    .MEMLINES (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .cmd_in      (cmd_in),
    .add_in      (add_in),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .wr_done     (wr_done),
    .read_count  (read_count),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Called at the negedge just after the accepting edge; expects the burst
  // LATENCY edges later with words base+0 .. base+15.
  task automatic collect_burst(input logic [31:0] base, input string name);
    int lat = 0;
    while (rd_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 4) begin
      n_fails++;
      $display("[TB] FAIL %s latency: got %0d edges, expected 4", name, lat);
    end
    for (int w = 0; w < 16; w++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== base + 32'(w) || rd_last !== (w == 15)) begin
        n_fails++;
        $display("[TB] FAIL %s word %0d: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                 name, w, rd_valid, rd_data, rd_last, base + 32'(w), (w == 15));
      end
      @(negedge clk);
    end
    n_checks++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h0) begin
      n_fails++;
      $display("[TB] FAIL %s end: valid=%b last=%b data=%h, expected 0 0 0",
               name, rd_valid, rd_last, rd_data);
    end
  endtask

  task automatic read_line(input logic [25:0] addr, input logic [31:0] base, input string name);
    @(negedge clk);
    req_valid = 1'b1;
    cmd_in    = 2'b01;
    add_in    = addr;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL %s ready: got %b, expected 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    collect_burst(base, name);
  endtask

  task automatic write_line(input logic [25:0] addr, input logic [31:0] base, input int gap,
                            input string name);
    int pulses = 0;
    @(negedge clk);
    req_valid = 1'b1;
    cmd_in    = 2'b10;
    add_in    = addr;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL %s ready: got %b, expected 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    for (int w = 0; w < 16; w++) begin
      wr_valid = 1'b1;
      wr_data  = base + 32'(w);
      @(negedge clk);
      wr_valid = 1'b0;
      wr_data  = 32'hDEAD_BEEF;
      if (wr_done === 1'b1) pulses++;
      if (w < 15) begin
        repeat (gap) begin
          @(negedge clk);
          if (wr_done === 1'b1) pulses++;
        end
      end
    end
    n_checks++;
    if (wr_done !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL %s wr_done after last word: got %b, expected 1", name, wr_done);
    end
    @(negedge clk);
    n_checks++;
    if (wr_done !== 1'b0 || pulses !== 1) begin
      n_fails++;
      $display("[TB] FAIL %s wr_done pulse: now=%b pulses=%0d, expected 0 and 1", name, wr_done, pulses);
    end
  endtask

  task automatic check_counts(input logic [31:0] exp_rd, input logic [31:0] exp_wr, input string name);
    n_checks++;
    if (read_count !== exp_rd || write_count !== exp_wr) begin
      n_fails++;
      $display("[TB] FAIL %s counts: read=%0d write=%0d, expected read=%0d write=%0d",
               name, read_count, write_count, exp_rd, exp_wr);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    add_in    = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'h0 || rd_last !== 1'b0 ||
        wr_done !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset outputs: ready=%b valid=%b data=%h last=%b done=%b, expected all 0",
               req_ready, rd_valid, rd_data, rd_last, wr_done);
    end
    check_counts(0, 0, "reset");
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL reset release ready: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_read_pattern();
    read_line(26'h0001234, 32'h1234_0000, "read_pattern");
    check_counts(1, 0, "read_pattern");
  endtask

  task automatic test_write_readback();
    write_line(26'h5, 32'hA000_0000, 2, "write_gaps");
    check_counts(1, 1, "write_gaps");
    read_line(26'h5, 32'hA000_0000, "write_readback");
    check_counts(2, 1, "write_readback");
  endtask

  task automatic test_alias();
    write_line(26'h005, 32'hB000_0000, 0, "alias_write");
    read_line(26'h105, 32'hB000_0000, "alias_read");
    check_counts(3, 2, "alias");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1;
    cmd_in    = 2'b01;
    add_in    = 26'h0000040;
    @(negedge clk);
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    while (rd_valid !== 1'b1 && read_count < 32'd10) @(negedge clk);
    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    cmd_in    = 2'b01;
    add_in    = 26'h0000077;
    for (int w = 3; w < 16; w++) begin
      n_checks++;
      if (req_ready !== 1'b0 || read_count !== 32'd4 || rd_data !== 32'h0040_0000 + 32'(w)) begin
        n_fails++;
        $display("[TB] FAIL held_req word %0d: ready=%b count=%0d data=%h, expected 0 4 %h",
                 w, req_ready, read_count, rd_data, 32'h0040_0000 + 32'(w));
      end
      @(negedge clk);
    end
    n_checks++;
    if (req_ready !== 1'b1 || rd_valid !== 1'b0 || read_count !== 32'd4) begin
      n_fails++;
      $display("[TB] FAIL held_req idle: ready=%b valid=%b count=%0d, expected 1 0 4",
               req_ready, rd_valid, read_count);
    end
    @(negedge clk);
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    n_checks++;
    if (req_ready !== 1'b0 || read_count !== 32'd5) begin
      n_fails++;
      $display("[TB] FAIL held_req accept: ready=%b count=%0d, expected 0 5", req_ready, read_count);
    end
    collect_burst(32'h0077_0000, "held_req_burst");
  endtask

  task automatic test_nop_ignored();
    @(negedge clk);
    req_valid = 1'b1;
    add_in    = 26'h0000033;
    for (int i = 0; i < 6; i++) begin
      cmd_in = (i < 3) ? 2'b00 : 2'b11;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rd_valid !== 1'b0 || wr_done !== 1'b0 ||
          read_count !== 32'd5 || write_count !== 32'd2) begin
        n_fails++;
        $display("[TB] FAIL nop cmd=%b: ready=%b valid=%b done=%b rc=%0d wc=%0d, expected 1 0 0 5 2",
                 cmd_in, req_ready, rd_valid, wr_done, read_count, write_count);
      end
    end
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0 || wr_done !== 1'b0) begin
        n_fails++;
        $display("[TB] FAIL nop aftermath: valid=%b done=%b, expected 0 0", rd_valid, wr_done);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    req_valid = 1'b1;
    cmd_in    = 2'b10;
    add_in    = 26'h9;
    @(negedge clk);
    req_valid = 1'b0;
    cmd_in    = 2'b00;
    for (int w = 0; w < 7; w++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hC000_0000 + 32'(w);
      @(negedge clk);
    end
    wr_data = 32'hC000_0007;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || rd_valid !== 1'b0 || wr_done !== 1'b0 || rd_data !== 32'h0 ||
        read_count !== 32'd0 || write_count !== 32'd0) begin
      n_fails++;
      $display("[TB] FAIL mid_write reset: ready=%b valid=%b done=%b data=%h rc=%0d wc=%0d, expected all 0",
               req_ready, rd_valid, wr_done, rd_data, read_count, write_count);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || wr_done !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_write release: ready=%b done=%b, expected 1 0", req_ready, wr_done);
    end
    read_line(26'h9, 32'h0009_0000, "mid_write_read");
    read_line(26'h5, 32'h0005_0000, "written_bit_cleared");
    check_counts(2, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_read_pattern();
    test_write_readback();
    test_alias();
    test_back_to_back();
    test_nop_ignored();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
